itf_bus_arbiter: RTL and testbench
==================================

ITF_BUS_ARBITER -- requirements
Module: itf_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing the itf addr/data bus.
REQ-002 The block SHALL have parameter AW, default 8, giving the address width.
REQ-003 The block SHALL have parameter DW, default 8, giving the data width.
REQ-004 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per tenure (legal range 1..255).
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port req, input, width N_REQ: per-requester bus request.
REQ-008 The block SHALL have port done, input, width N_REQ: per-requester early release, honoured only for the granted requester.
REQ-009 The block SHALL have port req_addr, input, width N_REQ*AW: packed requester addresses, requester i at bits [i*AW +: AW].
REQ-010 The block SHALL have port req_data, input, width N_REQ*DW: packed requester data, same packing as req_addr.
REQ-011 The block SHALL have port gnt, output, width N_REQ: registered, one-hot or zero grant.
REQ-012 The block SHALL have port bus_valid, output, width 1: registered; the shared bus carries a granted transfer.
REQ-013 The block SHALL have port bus_addr, output, width AW: registered shared bus address.
REQ-014 The block SHALL have port bus_data, output, width DW: registered shared bus data.
REQ-015 The block SHALL have port busy, output, width 1: high while state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, OWN and TURN.
REQ-017 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0.
REQ-018 In IDLE with req!=0, the block SHALL pick a winner g by round-robin: first set req bit at or above pointer ptr, wrapping N_REQ-1 -> 0.
REQ-019 On that IDLE edge, the block SHALL set gnt to one-hot(g), clear hold counter hcnt to 0 and enter OWN; latency from req sampled to gnt is 1 cycle.
REQ-020 Each OWN cycle, the block SHALL evaluate exit = done[g] | ~req[g] | (hcnt == MAX_HOLD-1), then increment hcnt.
REQ-021 On exit, the block SHALL set gnt to 0, set ptr to (g+1) mod N_REQ and enter TURN; gnt is therefore high for at most MAX_HOLD consecutive cycles.
REQ-022 TURN SHALL last exactly one cycle with gnt=0, then return to IDLE; the minimum gap between grants is 2 cycles with gnt=0.
REQ-023 Each edge where state is OWN, the block SHALL load bus_valid=1, bus_addr=req_addr[g] and bus_data=req_data[g]; the bus lags gnt by exactly 1 cycle.
REQ-024 Each edge where state is not OWN, the block SHALL load bus_valid=0 and leave bus_addr and bus_data holding their last value.
REQ-025 The block SHALL ignore done bits and req changes of non-granted requesters while in OWN; there is no preemption.
REQ-026 If done[g] and hcnt==MAX_HOLD-1 occur together, the block SHALL treat them as a single exit with identical behaviour.
REQ-027 ptr SHALL wrap from N_REQ-1 to 0.
REQ-028 hcnt SHALL be sized $clog2(MAX_HOLD+1) bits and SHALL never overflow.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL force state=IDLE, gnt=0, bus_valid=0, bus_addr=0, bus_data=0, ptr=0 and hcnt=0; busy is therefore 0.
REQ-030 Reset SHALL take priority over all other inputs, including mid-OWN; an interrupted tenure is discarded with no TURN cycle.
REQ-031 In the first cycle after rst falls, the block SHALL arbitrate normally from ptr=0.

Verification
REQ-032 Reset check: drive rst=1 for 2 cycles with req=4'hF -> gnt=0, bus_valid=0, bus_addr=0, busy=0 throughout.
REQ-033 Single requester: req[2]=1 with addr 0x5A, done[2] on the 3rd grant cycle -> gnt=4'b0100 for 3 cycles starting 1 cycle after req; bus_valid=1 and bus_addr=0x5A lag gnt by 1 cycle; then 2 cycles with gnt=0.
REQ-034 Round robin: req=4'hF constant, done pulsed on the first grant cycle -> grant order 0,1,2,3,0, each tenure 1 cycle, separated by 2 idle cycles.
REQ-035 Hold limit: req[1]=1 constant, done=0 -> gnt[1] high exactly 8 cycles, then TURN and IDLE, then re-granted to 1.
REQ-036 Request withdrawal: req[3] dropped on the 2nd OWN cycle -> gnt=0 on the next edge, and ptr=0 so the next grant goes to requester 0 if it requests.
REQ-037 Mid-tenure reset: rst=1 on the 4th OWN cycle of requester 2 -> next edge gnt=0 and bus_valid=0; after release with req=4'hF, requester 0 wins.

Source files
------------

// File: rtl/itf_bus_arbiter.sv
// -----------------------------------------------------------------------------
// itf_bus_arbiter
//
// Round-robin arbiter that lets N_REQ requesters share one registered
// address/data bus. A winner owns the bus for one tenure, which lasts until
// it signals done, drops its request, or reaches MAX_HOLD grant cycles. After
// each tenure there is one TURN cycle, then one IDLE cycle that arbitrates.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        per-requester bus request
//   done       per-requester early release (used only for the current owner)
//   req_addr   packed requester addresses, requester i at [i*AW +: AW]
//   req_data   packed requester data, same packing as req_addr
//   gnt        registered grant, one-hot or zero
//   bus_valid  registered; bus_addr/bus_data carry a granted transfer
//   bus_addr   registered shared bus address
//   bus_data   registered shared bus data
//   busy       high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module itf_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      done,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic                  bus_valid,
  output logic [AW-1:0]         bus_addr,
  output logic [DW-1:0]         bus_data,
  output logic                  busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // hcnt can reach MAX_HOLD (incremented on the exit edge), so it is sized
  // to hold that value and never wraps.
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [HW-1:0]   hcnt;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic            own_exit;

  // Round-robin pick: first requester at or above ptr, wrapping. Scanning
  // offsets from the far end down lets the nearest hit overwrite the others.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // Tenure ends on the owner's done, its request dropping, or the hold limit.
  // Other requesters' done/req never end someone else's tenure.
  assign own_exit = done[owner] | ~req[owner] | (hcnt == HW'(MAX_HOLD - 1));

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= '0;
      owner     <= '0;
      hcnt      <= '0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= N_REQ'(1) << pick_idx;
            owner <= pick_idx;
            hcnt  <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          hcnt <= hcnt + HW'(1);
          if (own_exit) begin
            gnt   <= '0;
            ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
            state <= TURN;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // The bus follows the owner one cycle behind gnt; outside a tenure the
      // address/data simply hold their last value.
      if (state == OWN) begin
        bus_valid <= 1'b1;
        bus_addr  <= req_addr[owner*AW +: AW];
        bus_data  <= req_data[owner*DW +: DW];
      end else begin
        bus_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_itf_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_itf_bus_arbiter
//
// Directed bench for itf_bus_arbiter (N_REQ=4, AW=8, DW=8, MAX_HOLD=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge. "Cycle i" means the sample taken i rising edges
// after the stimulus for the scenario was applied.
// -----------------------------------------------------------------------------
module tb_itf_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        bus_valid;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  itf_bus_arbiter #(
    .N_REQ   (4),
    .AW      (8),
    .DW      (8),
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .bus_valid(bus_valid),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'h0;
    done = 4'h0;
    step();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'hF;
    done = 4'h0;
    for (int i = 1; i <= 2; i++) begin
      step();
      vectors++;
      if (gnt !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_gnt cycle %0d: got %h want 0", i, gnt);
      end
      vectors++;
      if (bus_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_bus_valid cycle %0d: got %b want 0", i, bus_valid);
      end
      vectors++;
      if (bus_addr !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_bus_addr cycle %0d: got %h want 00", i, bus_addr);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy cycle %0d: got %b want 0", i, busy);
      end
    end
    rst = 1'b0;
    req = 4'h0;
  endtask

  // Requester 2 alone; other requesters' done bits pulse early and must be
  // ignored; done[2] on the 3rd grant cycle ends the tenure.
  task automatic test_single();
    logic [3:0] exp_gnt   [6] = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4};
    logic       exp_valid [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    req_addr[23:16] = 8'h5A;
    req_data[23:16] = 8'hC3;
    req = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i-1]) begin
        miscompares++;
        $display("FAIL single_gnt cycle %0d: got %h want %h", i, gnt, exp_gnt[i-1]);
      end
      vectors++;
      if (bus_valid !== exp_valid[i-1]) begin
        miscompares++;
        $display("FAIL single_bus_valid cycle %0d: got %b want %b", i, bus_valid, exp_valid[i-1]);
      end
      vectors++;
      if (busy !== exp_busy[i-1]) begin
        miscompares++;
        $display("FAIL single_busy cycle %0d: got %b want %b", i, busy, exp_busy[i-1]);
      end
      if (i >= 2) begin
        vectors++;
        if (bus_addr !== 8'h5A || bus_data !== 8'hC3) begin
          miscompares++;
          $display("FAIL single_bus_payload cycle %0d: got %h/%h want 5a/c3", i, bus_addr, bus_data);
        end
      end
      if (i == 1) done = 4'b1011;
      if (i == 2) done = 4'b0000;
      if (i == 3) done = 4'b0100;
      if (i == 4) done = 4'b0000;
    end
  endtask

  // All requesting, done always high: one-cycle tenures in order 0,1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] exp_gnt [13] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0,
                                 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1};
    logic [7:0] want_addr;
    do_reset();
    req_addr = 32'h13121110;
    req_data = 32'hA3A2A1A0;
    req  = 4'hF;
    done = 4'hF;
    for (int i = 1; i <= 13; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i-1]) begin
        miscompares++;
        $display("FAIL rr_gnt cycle %0d: got %h want %h", i, gnt, exp_gnt[i-1]);
      end
      if (i % 3 == 2) begin
        want_addr = 8'h10 + 8'((i - 2) / 3);
        vectors++;
        if (bus_valid !== 1'b1 || bus_addr !== want_addr) begin
          miscompares++;
          $display("FAIL rr_bus cycle %0d: got valid=%b addr=%h want valid=1 addr=%h",
                   i, bus_valid, bus_addr, want_addr);
        end
      end
    end
    done = 4'h0;
  endtask

  // Requester 1 holds req with no done: 8 grant cycles, TURN, IDLE, regrant.
  task automatic test_hold_limit();
    logic [3:0] exp_gnt   [11] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                                   4'h2, 4'h2, 4'h0, 4'h0, 4'h2};
    logic       exp_valid [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 11; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i-1]) begin
        miscompares++;
        $display("FAIL hold_gnt cycle %0d: got %h want %h", i, gnt, exp_gnt[i-1]);
      end
      vectors++;
      if (bus_valid !== exp_valid[i-1]) begin
        miscompares++;
        $display("FAIL hold_bus_valid cycle %0d: got %b want %b", i, bus_valid, exp_valid[i-1]);
      end
    end
  endtask

  // Requester 3 drops req on its 2nd grant cycle; ptr wraps to 0 so
  // requester 0 gets the next grant.
  task automatic test_withdraw();
    logic [3:0] exp_gnt [5] = '{4'h8, 4'h8, 4'h0, 4'h0, 4'h1};
    do_reset();
    req = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i-1]) begin
        miscompares++;
        $display("FAIL withdraw_gnt cycle %0d: got %h want %h", i, gnt, exp_gnt[i-1]);
      end
      if (i == 2) req = 4'b0001;
    end
  endtask

  // A finished tenure of requester 1 moves ptr to 2; requester 2 then owns
  // the bus and reset lands on its 4th grant cycle. Reset must clear ptr,
  // so requester 0 wins afterwards.
  task automatic test_mid_reset();
    logic [3:0] exp_gnt [9] = '{4'h2, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};
    do_reset();
    req  = 4'b0010;
    done = 4'b0010;
    for (int i = 1; i <= 9; i++) begin
      step();
      vectors++;
      if (gnt !== exp_gnt[i-1]) begin
        miscompares++;
        $display("FAIL midrst_gnt cycle %0d: got %h want %h", i, gnt, exp_gnt[i-1]);
      end
      if (i == 8) begin
        vectors++;
        if (bus_valid !== 1'b0 || busy !== 1'b0 || bus_addr !== 8'h00) begin
          miscompares++;
          $display("FAIL midrst_clear: got valid=%b busy=%b addr=%h want 0/0/00",
                   bus_valid, busy, bus_addr);
        end
      end
      if (i == 3) begin
        req  = 4'b0100;
        done = 4'b0000;
      end
      if (i == 7) begin
        rst = 1'b1;
        req = 4'hF;
      end
      if (i == 8) rst = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'h0;
    done     = 4'h0;
    req_addr = 32'h0;
    req_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_withdraw();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
